// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display back end.
//   SEG_*      : active-low seven-segment glyphs, bit order {dp,g,f,e,d,c,b,a}
//   DIG_*      : scan slot indices (0 = hour tens on an[3] ... 3 = minute units on an[0])
//   digit_glyph: maps a decimal digit to its glyph (non-decimal codes blank)
package clock_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] DIG_HT = 2'd0;
  localparam logic [1:0] DIG_HU = 2'd1;
  localparam logic [1:0] DIG_MT = 2'd2;
  localparam logic [1:0] DIG_MU = 2'd3;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/clock_display_scan_two_digit_bcd.sv
// Combinational binary-to-two-digit decimal split.
//   value : 7-bit binary input, 0..127
//   tens  : value / 10 (only meaningful when ovf = 0)
//   units : value % 10 (only meaningful when ovf = 0)
//   ovf   : 1 when value > 99 and the field cannot be shown in two digits
module two_digit_bcd (
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       ovf
);

  assign tens  = 4'(value / 7'd10);
  assign units = 4'(value % 7'd10);
  assign ovf   = (value > 7'd99);

endmodule

// File: rtl/clock_display_scan.sv
// Display back end of the lab digital clock: snapshots hour/minute once per
// frame, converts them to decimal (optionally 12-hour) and scans them onto a
// common-anode 4-digit seven-segment display.
//   clk, rst    : system clock, asynchronous active-high reset
//   hour,minute : binary time from the counter chain
//   mode_12h    : 1 = 12-hour display with leading-zero blanking and PM LED
//   blink_hour  : blank the hour digits during the blink off-phase
//   blink_min   : blank the minute digits during the blink off-phase
//   an          : active-low digit enables, an[3] = hour tens ... an[0] = minute units
//   seg         : active-low segments {dp,g,f,e,d,c,b,a}; dp on hour units is the colon
//   pm_led      : lit for 12:00..23:59 in 12-hour mode
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hour,
  input  logic [6:0] minute,
  input  logic       mode_12h,
  input  logic       blink_hour,
  input  logic       blink_min,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       pm_led
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_tick;
  logic [1:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [6:0]         cap_hour;
  logic [6:0]         cap_min;

  logic [6:0] h_disp;
  logic       h_oor;
  logic       pm_next;
  logic [3:0] h_tens, h_units, m_tens, m_units;
  logic       h_ovf, m_ovf;
  logic       slot_blink, slot_dash, slot_lz;
  logic [3:0] slot_digit;
  logic [7:0] slot_glyph;
  logic [7:0] seg_next;
  logic [3:0] an_next;

  // 12-hour remap of the captured hour; anything past 23 cannot be mapped
  // and is reported as out of range so the hour field shows dashes.
  always_comb begin
    h_disp  = cap_hour;
    h_oor   = 1'b0;
    pm_next = 1'b0;
    if (mode_12h) begin
      if (cap_hour >= 7'd24) begin
        h_oor = 1'b1;
      end else begin
        pm_next = (cap_hour >= 7'd12);
        if (cap_hour == 7'd0)
          h_disp = 7'd12;
        else if (cap_hour > 7'd12)
          h_disp = cap_hour - 7'd12;
      end
    end
  end

  two_digit_bcd u_bcd_hour (
    .value (h_disp),
    .tens  (h_tens),
    .units (h_units),
    .ovf   (h_ovf)
  );

  two_digit_bcd u_bcd_min (
    .value (cap_min),
    .tens  (m_tens),
    .units (m_units),
    .ovf   (m_ovf)
  );

  always_comb begin
    slot_blink = 1'b0;
    slot_dash  = 1'b0;
    slot_lz    = 1'b0;
    slot_digit = 4'd0;
    case (digit_idx)
      DIG_HT: begin
        slot_blink = blink_hour & ~blink_phase;
        slot_dash  = h_oor | h_ovf;
        slot_lz    = mode_12h & (h_tens == 4'd0);
        slot_digit = h_tens;
      end
      DIG_HU: begin
        slot_blink = blink_hour & ~blink_phase;
        slot_dash  = h_oor | h_ovf;
        slot_digit = h_units;
      end
      DIG_MT: begin
        slot_blink = blink_min & ~blink_phase;
        slot_dash  = m_ovf;
        slot_digit = m_tens;
      end
      default: begin
        slot_blink = blink_min & ~blink_phase;
        slot_dash  = m_ovf;
        slot_digit = m_units;
      end
    endcase

    if (slot_blink)
      slot_glyph = SEG_BLANK;
    else if (slot_dash)
      slot_glyph = SEG_DASH;
    else if (slot_lz)
      slot_glyph = SEG_BLANK;
    else
      slot_glyph = digit_glyph(slot_digit);

    // Colon rides on the hour-units dp and flashes with the blink phase.
    seg_next = slot_glyph & ~{(digit_idx == DIG_HU) & blink_phase, 7'b0};
    an_next  = ~(4'b1000 >> digit_idx);
  end

  // scan_tick is a registered pulse, so the displayed slot changes one cycle
  // after the prescaler reaches its terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      scan_tick   <= 1'b0;
      digit_idx   <= DIG_HT;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      cap_hour    <= '0;
      cap_min     <= '0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      pm_led      <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt == SCAN_LAST);
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      if (scan_tick) begin
        an        <= an_next;
        seg       <= seg_next;
        pm_led    <= pm_next;
        digit_idx <= digit_idx + 2'd1;
        // Snapshot while the last slot of the frame goes out, so the next
        // frame shows one consistent time.
        if (digit_idx == DIG_MU) begin
          cap_hour <= hour;
          cap_min  <= minute;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] hour = '0;
  logic [6:0] minute = '0;
  logic       mode_12h = 1'b0;
  logic       blink_hour = 1'b0;
  logic       blink_min = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       pm_led;

  int total = 0;
  int bad   = 0;

  // reference state
  int         n_edges;
  int         cap_h, cap_m;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_pm;

  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .hour       (hour),
    .minute     (minute),
    .mode_12h   (mode_12h),
    .blink_hour (blink_hour),
    .blink_min  (blink_min),
    .an         (an),
    .seg        (seg),
    .pm_led     (pm_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp_v, n_edges);
    end
  endtask

  // What a slot should show, worked out from the time value as a person
  // reading the clock would: map hour, split into decimal, then apply the
  // blink / dash / leading-zero / colon rules.
  function automatic logic [7:0] model_seg(int idx, int h, int m, bit md,
                                           bit bh, bit bm, bit ph);
    int hd, d;
    bit hdash, dash, blank;
    logic [7:0] g;
    hdash = md ? (h >= 24) : (h > 99);
    hd = h;
    if (md && h < 24) hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    case (idx)
      0:       d = hd / 10;
      1:       d = hd % 10;
      2:       d = m / 10;
      default: d = m % 10;
    endcase
    dash  = (idx < 2) ? hdash : (m > 99);
    blank = (idx < 2) ? (bh && !ph) : (bm && !ph);
    if (blank)                        g = 8'hFF;
    else if (dash)                    g = 8'hBF;
    else if (idx == 0 && md && d == 0) g = 8'hFF;
    else if (d <= 9)                  g = glyph[d];
    else                              g = 8'hFF;
    if (idx == 1 && ph) g[7] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    n_edges = 0;
    cap_h   = 0;
    cap_m   = 0;
    exp_an  = 4'b1111;
    exp_seg = 8'hFF;
    exp_pm  = 1'b0;
  endtask

  // One clock edge; inputs as seen at the edge are latched first.
  task automatic step();
    int  h0, m0, idx;
    bit  md0, bh0, bm0, ph;
    h0 = int'(hour); m0 = int'(minute);
    md0 = mode_12h; bh0 = blink_hour; bm0 = blink_min;
    @(posedge clk);
    n_edges++;
    #1;
    // slots update on edges 5, 9, 13, ... after reset release
    if (n_edges >= 5 && (n_edges - 1) % SCAN_DIV == 0) begin
      idx = ((n_edges - 5) / SCAN_DIV) % 4;
      ph  = (((n_edges - 1) / BLINK_DIV) % 2) == 0;
      exp_an  = ~(4'b1000 >> idx);
      exp_seg = model_seg(idx, cap_h, cap_m, md0, bh0, bm0, ph);
      exp_pm  = md0 && cap_h >= 12 && cap_h <= 23;
      if (idx == 3) begin
        cap_h = h0;
        cap_m = m0;
      end
    end
    chk("an", {4'h0, an}, {4'h0, exp_an});
    chk("seg", seg, exp_seg);
    chk("pm_led", {7'h0, pm_led}, {7'h0, exp_pm});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_pm", {7'h0, pm_led}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    hour = 7'd13; minute = 7'd5;
    rst = 1'b0;

    // 24-hour, then 12-hour with PM, then midnight as 12
    run(40);
    mode_12h = 1'b1;
    run(24);
    hour = 7'd0;
    run(24);

    // out of range hour in both modes, minute change mid-frame
    hour = 7'd100;
    run(20);
    mode_12h = 1'b0;
    run(6);
    minute = 7'd6;
    run(24);
    hour = 7'd30; mode_12h = 1'b1;
    run(20);

    // blinking across several phase toggles
    hour = 7'd13; minute = 7'd42; blink_hour = 1'b1;
    run(200);
    blink_min = 1'b1;
    run(140);
    blink_hour = 1'b0;
    run(80);
    blink_min = 1'b0;

    // reset in the middle of a frame
    run(7);
    mid_reset();
    run(30);

    // rollover 23:59 -> 00:00 with the two fields changing apart
    mode_12h = 1'b0; hour = 7'd23; minute = 7'd59;
    run(30);
    minute = 7'd0;
    run(3);
    hour = 7'd0;
    run(30);
    minute = 7'd59; hour = 7'd23;
    run(17);
    hour = 7'd0;
    run(9);
    minute = 7'd0;
    run(30);

    // random traffic
    for (int it = 0; it < 200; it++) begin
      hour       = 7'($urandom_range(0, 127));
      minute     = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) hour = 7'($urandom_range(0, 23));
      mode_12h   = 1'($urandom);
      blink_hour = ($urandom_range(0, 3) == 0);
      blink_min  = ($urandom_range(0, 3) == 0);
      run($urandom_range(1, 14));
      if ($urandom_range(0, 39) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Display back end of the lab digital clock.
- Consumes the 7-bit binary hour and minute values from the counter chain and converts them to decimal digits, with optional 12-hour remapping.
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display.
- Provides per-field blinking for set mode, a 1 Hz colon/dp indicator and a PM LED.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit is driven (100 MHz gives 1 kHz per digit); must be >= 2.
- BLINK_DIV, 50000000, clk cycles per blink_phase half-period (0.5 s at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- hour  in  7  binary hour from the hour counter, 0..127
- minute  in  7  binary minute from the minute counter, 0..127
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- blink_hour  in  1  1 = blank both hour digits during the blink off-phase
- blink_min  in  1  1 = blank both minute digits during the blink off-phase
- an  out  4  digit enables, active-low; an[3] = hour tens, an[2] = hour units, an[1] = minute tens, an[0] = minute units
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- pm_led  out  1  PM indicator

Behaviour:
- Reset state: an=4'b1111, seg=8'hFF, pm_led=0, scan_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=1, captured hour and minute = 0.
- Scan prescaler:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - scan_tick is asserted for one cycle when scan_cnt = SCAN_DIV-1.
  - On scan_tick, digit_idx advances 0→1→2→3→0. Index 0 = an[3] and index 3 = an[0].
- Frame capture:
  - hour and minute are sampled into internal registers on the scan_tick that wraps digit_idx from 3 to 0.
  - Within one frame all four digits show one consistent snapshot; this prevents tearing while the counter chain rolls over.
- Output timing:
  - an and seg are registered and change on the clock edge after scan_tick, one cycle latency.
  - Exactly one an bit is low at any time after the first scan_tick.
  - an stays 4'b1111 from reset until the first scan_tick.
- Blink timer:
  - blink_cnt counts 0..BLINK_DIV-1; at the wrap it toggles blink_phase.
  - It runs freely and is independent of the scan prescaler.
- Hour mapping, applied to the captured hour:
  - 24h mode: h_disp = hour, pm_led = 0.
  - 12h mode: hour 0 → 12; 1..12 → unchanged; 13..23 → hour-12. pm_led = 1 when 12 <= hour <= 23.
  - 12h mode with hour >= 24: treat as out of range.
- Digit conversion:
  - Values 0..99 map to tens = v/10 and units = v%10.
  - Any value > 99, or hour >= 24 in 12h mode, shows '-' (segment g only) on both digits of that field; pm_led = 0 in that case.
- Leading zero: in 12h mode only, a zero hour tens digit is blanked (seg = 8'hFF for its slot). The minute tens digit is never blanked.
- Blinking: when blink_hour=1 and blink_phase=0, indices 0 and 1 output seg=8'hFF while the anode still scans. blink_min does the same for indices 2 and 3. Both may be active at once.
- Colon: dp is active (seg[7]=0) only on index 1 and only while blink_phase=1; otherwise seg[7]=1.
- Priority per digit slot, highest first: blink blank > out-of-range '-' > leading-zero blank > digit glyph.
- Input changes mid-frame have no effect until the next capture.
- Mode and blink inputs are not captured: they take effect at the next scan_tick.
- Reset mid-frame returns all state to the reset values immediately, asynchronously.

Decomposition:
- Shared package `clock_disp_pkg` holds:
  - glyph constants SEG_0..SEG_9, SEG_DASH (8'hBF), SEG_BLANK (8'hFF);
  - digit index constants DIG_HT=0, DIG_HU=1, DIG_MT=2, DIG_MU=3.
- One combinational sub-module, `two_digit_bcd`: 7-bit input → tens[3:0], units[3:0], ovf (value > 99). It is instantiated twice, for hour and minute.

Test Plan:
Run all scenarios with SCAN_DIV=4 and BLINK_DIV=64.
- rst pulse mid-operation → an=1111, seg=FF, pm_led=0 the same cycle; first an=0111 appears 5 cycles after rst deasserts.
- hour=13, minute=5, mode_12h=0, no blink, over one frame → an 0111/1011/1101/1110 carry seg of 1, 3 (dp low if phase=1), 0, 5; pm_led=0.
- Same inputs with mode_12h=1 → hour tens slot blank (FF), units '1', pm_led=1. Then hour=0 → displays "12", pm_led=0.
- hour=100 → both hour slots show SEG_DASH while minute digits stay correct. Then change minute mid-frame from 5 to 6 → the old digits persist until the next index-0 frame.
- blink_hour=1 → hour slots are FF while blink_phase=0 and glyphs return while phase=1; phase toggles every 64 cycles; minute slots are unaffected.
- Rollover hour 23→0 with minute 59→0 changing between captures → no frame ever mixes old hour with new minute.
